// File: rtl/tap_divider_pkg.sv
// Shared mix-mode encoding and the tap combine function for the tap divider.
package tap_divider_pkg;

  localparam int MIX_MAX_TAPS = 32;

  typedef enum logic [1:0] {
    MIX_OR   = 2'b00,
    MIX_XOR  = 2'b01,
    MIX_AND  = 2'b10,
    MIX_PRIO = 2'b11
  } mix_mode_t;

  // Callers zero-extend narrower tap vectors. Unused sel bits are 0, so they never contribute.
  function automatic logic tap_mix(input logic [MIX_MAX_TAPS-1:0] count_slice,
                                   input logic [MIX_MAX_TAPS-1:0] sel,
                                   input mix_mode_t               mode);
    logic [MIX_MAX_TAPS-1:0] t;
    logic                    r;
    t = count_slice & sel;
    r = 1'b0;
    case (mode)
      MIX_OR:  r = |t;
      MIX_XOR: r = ^t;
      MIX_AND: r = (sel != '0) && (t == sel);
      MIX_PRIO: begin
        // The last match in the ascending scan is the highest selected tap.
        for (int i = 0; i < MIX_MAX_TAPS; i++)
          if (sel[i]) r = count_slice[i];
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tdiv_shift_reg.sv
// Serial-in shift register, advanced by a clock enable. q[0] holds the newest bit.
module tdiv_shift_reg #(
  parameter int SR_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                din,
  output logic [SR_DEPTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)         q <= '0;
    else if (shift_en) q <= {q[SR_DEPTH-2:0], din};
  end

endmodule

// File: rtl/tap_divider_shifter.sv
// Prescaler with mixed frequency taps driving a registered tone, and a slow
// tick that clock-enables a serial shift register. Single clock domain.
module tap_divider_shifter
  import tap_divider_pkg::*;
#(
  parameter int DIV_BITS    = 13,
  parameter int NUM_TAPS    = 6,
  parameter int TAP_BASE    = 6,
  parameter int SR_TICK_BIT = 12,
  parameter int SR_DEPTH    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [NUM_TAPS-1:0] tap_sel,
  input  logic [1:0]          mix_mode,
  input  logic                sr_din,
  output logic                tone_out,
  output logic                slow_clk,
  output logic                sr_tick,
  output logic [SR_DEPTH-1:0] sr_q
);

  logic [DIV_BITS-1:0] count;
  logic                rise;
  logic                tone_d;

  // Rise fires on the edge that carries count[SR_TICK_BIT] from 0 to 1.
  generate
    if (SR_TICK_BIT == 0) begin : g_rise_lsb
      assign rise = en & ~count[0];
    end else begin : g_rise
      assign rise = en & (&count[SR_TICK_BIT-1:0]) & ~count[SR_TICK_BIT];
    end
  endgenerate

  assign tone_d = tap_mix(MIX_MAX_TAPS'(count[TAP_BASE +: NUM_TAPS]),
                          MIX_MAX_TAPS'(tap_sel),
                          mix_mode_t'(mix_mode));

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tone_out <= 1'b0;
      sr_tick  <= 1'b0;
    end else begin
      if (en) count <= count + DIV_BITS'(1);
      tone_out <= tone_d;
      sr_tick  <= rise;
    end
  end

  assign slow_clk = count[DIV_BITS-1];

  tdiv_shift_reg #(.SR_DEPTH(SR_DEPTH)) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (rise),
    .din      (sr_din),
    .q        (sr_q)
  );

endmodule
